// File: rtl/inst_rr_scheduler.sv
// Round-robin owner scheduler for a shared resource slot with a one-cycle turnaround between owners.
// Optional grant hold limit compiled in with `define INST_RR_SCHED_TIMEOUT_EN.
module inst_rr_scheduler #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    // First set request at or after p, wrapping; MSB of the result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] p);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] cand;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDW'((int'(p) + i) % N_REQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    state_t           state_r;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   owner_r;
    logic [N_REQ-1:0] gnt_r;
    logic [IDW-1:0]   gnt_id_r;
    logic             busy_r;

    logic             pick_found_s;
    logic [IDW-1:0]   pick_idx_s;
    logic             owner_done_s;
    logic [IDW-1:0]   ptr_next_s;
    logic             hold_limit_s;

    // Arbitration result and owner release decode.
    always_comb begin
        {pick_found_s, pick_idx_s} = rr_pick(req, ptr_r);
        owner_done_s = rel[owner_r] | ~req[owner_r];
        if (owner_r == IDW'(N_REQ - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = owner_r + IDW'(1);
        end
    end

`ifdef INST_RR_SCHED_TIMEOUT_EN
    logic [7:0] hold_cnt_r;
    logic       timeout_r;

    assign hold_limit_s  = (hold_cnt_r == 8'(MAX_HOLD - 1));
    assign timeout_pulse = timeout_r;

    // Hold counter is zero outside GRANT, so it is cleared on every GRANT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            if (state_r == GRANT) begin
                if (owner_done_s || hold_limit_s) begin
                    hold_cnt_r <= 8'd0;
                    timeout_r  <= ~owner_done_s;
                end else begin
                    hold_cnt_r <= hold_cnt_r + 8'd1;
                end
            end else begin
                hold_cnt_r <= 8'd0;
            end
        end
    end
`else
    assign hold_limit_s  = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Ownership FSM with registered outputs; the GAP cycle arbitrates for the following cycle,
    // so a waiting requester is granted right after the single turnaround cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ptr_r    <= {IDW{1'b0}};
            owner_r  <= {IDW{1'b0}};
            gnt_r    <= {N_REQ{1'b0}};
            gnt_id_r <= {IDW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, GAP: begin
                    if (pick_found_s) begin
                        state_r  <= GRANT;
                        owner_r  <= pick_idx_s;
                        gnt_r    <= ONE_HOT_LSB << pick_idx_s;
                        gnt_id_r <= pick_idx_s;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        gnt_r    <= {N_REQ{1'b0}};
                        gnt_id_r <= {IDW{1'b0}};
                        busy_r   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (owner_done_s || hold_limit_s) begin
                        state_r  <= GAP;
                        ptr_r    <= ptr_next_s;
                        gnt_r    <= {N_REQ{1'b0}};
                        gnt_id_r <= {IDW{1'b0}};
                        busy_r   <= 1'b0;
                    end else begin
                        state_r  <= GRANT;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    gnt_r    <= {N_REQ{1'b0}};
                    gnt_id_r <= {IDW{1'b0}};
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_r;
    assign gnt_id = gnt_id_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Scoreboard bench for inst_rr_scheduler: directed scenarios plus random traffic against an ownership model.
module tb_inst_rr_scheduler;

    localparam int N        = 5;
    localparam int MAX_HOLD = 4;
`ifdef INST_RR_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = 5'd0;
    logic [4:0] rel = 5'd0;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout_pulse;

    inst_rr_scheduler #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .rel           (rel),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       tp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Model: owner index (-1 when nobody holds), rotating start index, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic model_step(input logic [4:0] r, input logic [4:0] l, output exp_t e);
        bit done;
        bit lim;
        bit tp;
        int pick;
        int c;
        tp   = 1'b0;
        pick = -1;
        if (m_owner >= 0) begin
            done = (((l >> m_owner) & 5'd1) != 5'd0) || (((r >> m_owner) & 5'd1) == 5'd0);
            lim  = TO_EN && (m_held == MAX_HOLD);
            if (done || lim) begin
                tp      = !done;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (pick < 0 && (((r >> c) & 5'd1) != 5'd0)) pick = c;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_held  = 1;
            end
        end
        e.gnt  = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'b00000;
        e.id   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.busy = (m_owner >= 0);
        e.tp   = tp;
    endtask

    // Drive one cycle of inputs; the model predicts the outputs after the consuming edge.
    task automatic cycle(input logic [4:0] r, input logic [4:0] l);
        exp_t e;
        req = r;
        rel = l;
        @(posedge clk);
        model_step(r, l, e);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Monitor: one prediction per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout_pulse} !== mon_e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                         $time, gnt, gnt_id, busy, timeout_pulse, mon_e.gnt, mon_e.id, mon_e.busy, mon_e.tp);
            end
        end
    end

    initial begin
        logic [4:0] rr;
        logic [4:0] rl;
        #12;
        check("reset_outputs", {gnt, gnt_id, busy, timeout_pulse}, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // single requester 2, then release
        repeat (3) cycle(5'b00100, 5'b00000);
        cycle(5'b00100, 5'b00100);
        repeat (3) cycle(5'b00000, 5'b00000);

        // all requesting, each owner releases after three cycles
        repeat (40) begin
            rl = (m_owner >= 0 && m_held >= 3) ? (5'b00001 << m_owner) : 5'b00000;
            cycle(5'b11111, rl);
        end
        cycle(5'b00000, 5'b00000);
        cycle(5'b00000, 5'b00000);

        // owner 1 unaffected by a non-owner toggling req/rel, then drops req
        repeat (2) cycle(5'b00010, 5'b00000);
        repeat (3) begin
            cycle(5'b01010, 5'b01000);
            cycle(5'b00010, 5'b00000);
        end
        cycle(5'b00000, 5'b00000);
        repeat (4) cycle(5'b11111, 5'b00000);
        cycle(5'b00000, 5'b00000);
        cycle(5'b00000, 5'b00000);

        // long hold with a competing requester (timeout exercised when compiled in)
        repeat (14) cycle(5'b00011, 5'b00000);
        cycle(5'b00000, 5'b00000);

        // random traffic with sparse releases
        repeat (600) begin
            rr = 5'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
            cycle(rr, rl);
        end
        cycle(5'b00000, 5'b00000);
        cycle(5'b00000, 5'b00000);

        // reset in the middle of requester 3's grant
        repeat (4) if (m_owner != 3) cycle(5'b01000, 5'b00000);
        repeat (2) cycle(5'b11111, 5'b00000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_grant", {gnt, gnt_id, busy, timeout_pulse}, 10'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(5'b11111, 5'b00000);
        @(negedge clk);
        #1;
        check("first_grant_after_reset", {gnt, gnt_id, busy, timeout_pulse}, {5'b00001, 3'd0, 1'b1, 1'b0});
        repeat (3) cycle(5'b11111, 5'b00000);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predictions left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
